// File: rtl/vend_change_dispenser.sv
// Coin-return sequencer: greedy quarter/dime/nickel ejection over a valid/ack hopper handshake.
// Optional hopper-ack timeout with a sticky FAULT state is enabled by defining CHANGE_TIMEOUT_EN.
module vend_change_dispenser #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change_bcd,
  input  logic       hopper_ack,
  output logic       eject_valid,
  output logic [2:0] eject_coin,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] remaining_bcd
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_EJECT  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [2:0] COIN_N = 3'b001;
  localparam logic [2:0] COIN_D = 3'b010;
  localparam logic [2:0] COIN_Q = 3'b100;

  // A zero-length gap still spends the one GAP cycle before moving on.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  if ((CNT_W < $clog2(GAP_CYCLES + 1)) || (CNT_W < $clog2(TIMEOUT_CYCLES + 1))) begin : g_bad_cnt_w
    $error("CNT_W too narrow for GAP_CYCLES/TIMEOUT_CYCLES");
  end

  function automatic logic [6:0] coin_value(input logic [2:0] coin);
    case (coin)
      COIN_Q:  coin_value = 7'd25;
      COIN_D:  coin_value = 7'd10;
      COIN_N:  coin_value = 7'd5;
      default: coin_value = 7'd0;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] value);
    logic [3:0] tens;
    logic [6:0] rest;
    tens = 4'd0;
    rest = value;
    for (int i = 0; i < 9; i++) begin
      if (rest >= 7'd10) begin
        rest = rest - 7'd10;
        tens = tens + 4'd1;
      end
    end
    to_bcd = {tens, rest[3:0]};
  endfunction

  logic [2:0]       state_q, state_d;
  logic [6:0]       rem_q, rem_d;
  logic [7:0]       rem_bcd_q, rem_bcd_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             eject_valid_q, eject_valid_d;
  logic [2:0]       eject_coin_q, eject_coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef CHANGE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    rem_bcd_d     = rem_bcd_q;
    gap_cnt_d     = gap_cnt_q;
    eject_valid_d = eject_valid_q;
    eject_coin_d  = eject_coin_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
`ifdef CHANGE_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_bcd_d = change_bcd;
          busy_d    = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((rem_bcd_q[7:4] > 4'd9) || ((rem_bcd_q[3:0] != 4'd0) && (rem_bcd_q[3:0] != 4'd5))) begin
          error_d   = 1'b1;
          busy_d    = 1'b0;
          rem_bcd_d = 8'h00;
          state_d   = S_IDLE;
        end else begin
          rem_d = (7'(rem_bcd_q[7:4]) * 7'd10) + 7'(rem_bcd_q[3:0]);
          if (rem_d == 7'd0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (rem_q >= 7'd25) begin
          eject_coin_d = COIN_Q;
        end else if (rem_q >= 7'd10) begin
          eject_coin_d = COIN_D;
        end else begin
          eject_coin_d = COIN_N;
        end
        eject_valid_d = 1'b1;
        state_d       = S_EJECT;
`ifdef CHANGE_TIMEOUT_EN
        to_cnt_d      = '0;
`endif
      end
      S_EJECT: begin
        if (hopper_ack) begin
          rem_d         = rem_q - coin_value(eject_coin_q);
          rem_bcd_d     = to_bcd(rem_d);
          eject_valid_d = 1'b0;
          eject_coin_d  = 3'b000;
          gap_cnt_d     = '0;
          state_d       = S_GAP;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          eject_valid_d = 1'b0;
          eject_coin_d  = 3'b000;
          error_d       = 1'b1;
          state_d       = S_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (rem_q != 7'd0) begin
            state_d = S_SELECT;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef CHANGE_TIMEOUT_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rem_q         <= 7'd0;
      rem_bcd_q     <= 8'h00;
      gap_cnt_q     <= '0;
      eject_valid_q <= 1'b0;
      eject_coin_q  <= 3'b000;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      rem_bcd_q     <= rem_bcd_d;
      gap_cnt_q     <= gap_cnt_d;
      eject_valid_q <= eject_valid_d;
      eject_coin_q  <= eject_coin_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
`ifdef CHANGE_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
`endif
    end
  end

  assign eject_valid   = eject_valid_q;
  assign eject_coin    = eject_coin_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign remaining_bcd = rem_bcd_q;

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Sequences coin return after a vend. It accepts a change amount in packed BCD cents from the vending FSM's change states. It drives a coin hopper one coin at a time over a valid/ack handshake, using a greedy order: quarter, then dime, then nickel. It sits between the vending-machine FSM, which issues `start` while in a change state, and the physical hopper interface.

Parameters:
- GAP_CYCLES, 4, idle cycles inserted after each acknowledged coin before the next eject.
- TIMEOUT_CYCLES, 1000, cycles to wait for hopper_ack before faulting (used only with the optional feature).
- CNT_W, 10, width of the gap and timeout counters; must hold max(GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to dispense change_bcd; sampled only in IDLE.
- change_bcd  in  8  change amount, two BCD digits, cents (8'h00..8'h95).
- hopper_ack  in  1  hopper accepted the current coin; sampled while eject_valid=1.
- eject_valid  out  1  coin request pending to hopper.
- eject_coin  out  3  one-hot coin type: 3'b001 nickel, 3'b010 dime, 3'b100 quarter; 3'b000 when eject_valid=0.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse when the full amount has been ejected.
- error  out  1  one-cycle pulse when the request is rejected (invalid BCD or not a multiple of 5); also used as the fault pulse.
- remaining_bcd  out  8  change still owed, packed BCD; 8'h00 in IDLE.

Behaviour:
- All outputs reset to 0. State resets to IDLE. Reset wins over every other input in the same cycle, including mid-eject; the pending coin is abandoned.
- States: IDLE, CHECK, SELECT, EJECT, GAP, DONE, plus FAULT with the optional feature.
- IDLE:
  - start=1 → latch change_bcd, assert busy, go to CHECK.
  - start is ignored in every other state; no queuing.
- CHECK (1 cycle):
  - Either nibble > 9, or low nibble not 0 or 5 → pulse error, go to IDLE with busy=0. No coin is ejected.
  - Otherwise convert to binary cents (7 bits, 0..95) and go to SELECT.
  - An amount of 0 goes straight to DONE.
- SELECT (1 cycle):
  - Pick the largest coin ≤ remaining (25, then 10, then 5).
  - Set eject_coin to that coin and eject_valid=1, then go to EJECT.
- EJECT:
  - Hold eject_valid and eject_coin stable until hopper_ack=1.
  - On the ack cycle: subtract the coin value from remaining; drop eject_valid next cycle; go to GAP.
  - hopper_ack while eject_valid=0 is ignored.
- GAP:
  - Count GAP_CYCLES cycles.
  - Then go to SELECT if remaining ≠ 0, else to DONE.
  - GAP_CYCLES=0 means go to SELECT or DONE on the next cycle.
- DONE (1 cycle): pulse done, deassert busy, go to IDLE.
- remaining_bcd:
  - Is the binary-to-BCD image of the remaining count.
  - Updates the cycle after each ack.
  - Equals the latched change_bcd during CHECK and SELECT before the first ack.
- Latency: start to first eject_valid is 3 cycles (start → CHECK → SELECT → eject_valid high).
- Coin sequence is exact greedy. Example: 95 = Q,Q,Q,D,D. Example: 40 = Q,D,N.
- Simultaneous hopper_ack and reset: reset wins; remaining is not decremented.

Optional Feature:
- CHANGE_TIMEOUT_EN defined:
  - In EJECT, a counter runs from entry.
  - If TIMEOUT_CYCLES elapse with no hopper_ack: drop eject_valid, pulse error, go to FAULT.
  - FAULT holds busy=1 and remaining_bcd frozen until reset.
- CHANGE_TIMEOUT_EN not defined:
  - No timeout counter and no FAULT state.
  - EJECT waits indefinitely for hopper_ack.

Test Plan:
- Reset, then start with change_bcd=8'h40, ack each eject after 2 cycles → eject_coin sequence 100,010,001. remaining_bcd steps 40→15→05→00. One done pulse. busy falls with done.
- start with change_bcd=8'h95, ack immediately, GAP_CYCLES=4 → five ejects Q,Q,Q,D,D. Each eject_valid rising edge is 6 cycles after the previous one (ack cycle + 4 gap + SELECT). done pulses once.
- start with change_bcd=8'h12 and with 8'h3A → error pulse 2 cycles after start. eject_valid never asserts. busy=0 after. remaining_bcd=0.
- start with change_bcd=8'h00 → done pulse with no eject. A second start asserted while busy during a 8'h20 transaction is ignored; only D,D is ejected.
- Assert reset while eject_valid=1 during a 8'h25 transaction → next cycle all outputs are 0 and state is IDLE. A subsequent start of 8'h05 ejects exactly one nickel.
- With CHANGE_TIMEOUT_EN and TIMEOUT_CYCLES=20, start with 8'h10 and never ack → eject_valid drops after 20 cycles, error pulses, busy stays 1, remaining_bcd=8'h10 until reset.
